// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// the hardwired zero register index and the supported port-count limits.
package regfile_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int ZERO_REG_INDEX     = 0;
  localparam int MAX_READ_PORTS     = 4;
  localparam int MAX_WRITE_PORTS    = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by issue, cleared by any write-back,
// with issue taking precedence when both hit the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  output logic [(2**ADDR_WIDTH)-1:0]      pending,
  output logic                            any_pending
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] pending_reg;
  logic [DEPTH-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;

      always_comb begin
        clr_hit = 1'b0;
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi)))
            clr_hit = 1'b1;
        end
        set_hit = issue_en && (issue_addr == ADDR_WIDTH'(gi)) &&
                  !((ZERO_REG != 0) && (gi == ZERO_REG_INDEX));
        // A new writer replaces the retiring one, so set outranks clear.
        if (set_hit)
          pending_next[gi] = 1'b1;
        else if (clr_hit)
          pending_next[gi] = 1'b0;
        else
          pending_next[gi] = pending_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      pending_reg <= '0;
    else
      pending_reg <= pending_next;
  end

  assign pending     = pending_reg;
  assign any_pending = |pending_reg;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with highest-port-wins writes, same-cycle write
// bypass, optional hardwired zero register and a RAW-hazard scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_pending,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  output logic                            any_pending
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_INDEX);

  logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  any_pending_raw;

  // Later ports are applied last, so the highest port index wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_reg[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ZERO_ADDR)))
          regs_reg[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .pending     (pending),
    .any_pending (any_pending_raw)
  );

  assign any_pending = any_pending_raw && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic                  hit;
      logic [DATA_WIDTH-1:0] fwd_data;

      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
            hit      = 1'b1;
            fwd_data = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      always_comb begin
        rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[addr];
        rd_pending[gi]                      = pending[addr];
        if ((BYPASS != 0) && hit) begin
          rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = fwd_data;
          rd_pending[gi]                      = 1'b0;
        end
        if (reset || ((ZERO_REG != 0) && (addr == ZERO_ADDR))) begin
          rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
          rd_pending[gi]                      = 1'b0;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_register_file_mp.sv
// Drives a bypassing and a non-bypassing register file with the same stimulus
// and compares both against a simple array-based reference model.
module tb_register_file_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_pend_b, rd_pend_n;
  logic        any_b, any_n;

  logic [31:0] mem  [32];
  logic        pend [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_pending(rd_pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .any_pending(any_b)
  );

  register_file_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_pending(rd_pend_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .any_pending(any_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] raddr(input int k);
    logic [9:0] v;
    v = rd_addr;
    return v[k*5 +: 5];
  endfunction

  function automatic logic wr_hits(input logic [4:0] a);
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*5 +: 5] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(input int k, input bit byp);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr(k);
    if (reset || a == 5'd0) return 32'h0;
    v = mem[a];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_pend(input int k, input bit byp);
    logic [4:0] a;
    a = raddr(k);
    if (reset) return 1'b0;
    if (byp && wr_hits(a)) return 1'b0;
    return pend[a];
  endfunction

  function automatic logic exp_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) r |= pend[i];
    return r && !reset;
  endfunction

  // Wait to the falling edge and compare every output of both instances.
  task automatic settle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("data_b[%0d] a=%0d", k, raddr(k)), rd_data_b[k*32 +: 32], exp_data(k, 1'b1));
      chk($sformatf("data_n[%0d] a=%0d", k, raddr(k)), rd_data_n[k*32 +: 32], exp_data(k, 1'b0));
      chk($sformatf("pend_b[%0d] a=%0d", k, raddr(k)), {31'b0, rd_pend_b[k]}, {31'b0, exp_pend(k, 1'b1)});
      chk($sformatf("pend_n[%0d] a=%0d", k, raddr(k)), {31'b0, rd_pend_n[k]}, {31'b0, exp_pend(k, 1'b0)});
    end
    chk("any_b", {31'b0, any_b}, {31'b0, exp_any()});
    chk("any_n", {31'b0, any_n}, {31'b0, exp_any()});
  endtask

  // Apply this cycle's effects to the model, then advance past the edge.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = 32'h0;
        pend[i] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) begin
          pend[wr_addr[j*5 +: 5]] = 1'b0;
          if (wr_addr[j*5 +: 5] != 5'd0) mem[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
        end
      end
      if (issue_en && issue_addr != 5'd0) pend[issue_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    wr_en[port] = 1'b1;
    wr_addr[port*5 +: 5] = a;
    wr_data[port*32 +: 32] = d;
  endtask

  task automatic rd(input int port, input logic [4:0] a);
    rd_addr[port*5 +: 5] = a;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      pend[i] = 1'b0;
    end
    idle(); reset = 1'b1; issue_en = 1'b1; issue_addr = 5'd3; settle(); tick();

    // Reset clears a preloaded register.
    idle(); wr(0, 5'd5, 32'hDEADBEEF); issue_en = 1'b1; issue_addr = 5'd5; settle(); tick();
    idle(); reset = 1'b1; rd(0, 5'd5); settle(); tick();
    idle(); rd(0, 5'd5); settle();
    chk("reset_r5", rd_data_b[31:0], 32'h0);
    chk("reset_any", {31'b0, any_b}, 32'h0);
    tick();

    // Basic write with same-cycle read on port 1.
    idle(); wr(0, 5'd7, 32'h12345678); rd(1, 5'd7); settle();
    chk("byp_r7", rd_data_b[63:32], 32'h12345678);
    chk("nobyp_r7", rd_data_n[63:32], 32'h0);
    tick();
    idle(); rd(1, 5'd7); settle();
    chk("read_r7", rd_data_n[63:32], 32'h12345678);
    tick();

    // Dual write to the same register: port 1 wins.
    idle(); wr(0, 5'd3, 32'hAAAA0000); wr(1, 5'd3, 32'h0000BBBB); rd(0, 5'd3); settle();
    chk("conflict_byp", rd_data_b[31:0], 32'h0000BBBB);
    tick();
    idle(); rd(0, 5'd3); rd(1, 5'd3); settle();
    chk("conflict_rd", rd_data_n[63:32], 32'h0000BBBB);
    tick();

    // Zero register ignores writes and issues.
    idle(); wr(1, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0); issue_en = 1'b1; issue_addr = 5'd0; settle(); tick();
    idle(); rd(0, 5'd0); settle();
    chk("zero_any", {31'b0, any_b}, 32'h0);
    tick();

    // Scoreboard lifecycle on r9.
    idle(); issue_en = 1'b1; issue_addr = 5'd9; settle(); tick();
    idle(); rd(0, 5'd9); settle();
    chk("r9_pend", {31'b0, rd_pend_b[0]}, 32'h1);
    tick();
    idle(); wr(0, 5'd9, 32'h55); rd(0, 5'd9); settle();
    chk("r9_byp_pend", {31'b0, rd_pend_b[0]}, 32'h0);
    chk("r9_nobyp_pend", {31'b0, rd_pend_n[0]}, 32'h1);
    tick();
    idle(); rd(0, 5'd9); settle();
    chk("r9_any_clear", {31'b0, any_b}, 32'h0);
    tick();

    // Set and clear on the same edge: set wins.
    idle(); issue_en = 1'b1; issue_addr = 5'd4; settle(); tick();
    idle(); issue_en = 1'b1; issue_addr = 5'd4; wr(0, 5'd4, 32'h11); settle(); tick();
    idle(); rd(1, 5'd4); settle();
    chk("r4_data", rd_data_n[63:32], 32'h11);
    chk("r4_pend", {31'b0, rd_pend_n[1]}, 32'h1);
    tick();
    idle(); wr(1, 5'd4, 32'h22); settle(); tick();
    idle(); rd(1, 5'd4); settle();
    chk("r4_cleared", {31'b0, rd_pend_n[1]}, 32'h0);
    tick();

    // Randomised traffic over a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 39) == 0);
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      issue_en = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
